// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the JOF32 decode stage and the hazard controller: ID-stage
// instruction fields, branch/memory status in, pipeline enables, forwarding selects and counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_wr;
  logic              id_sel_ld;
  logic              branch_taken;
  logic              mem_busy;
  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_en;
  logic              id_ex_bubble;
  logic              ex_mem_en;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_wr,
           id_sel_ld, branch_taken, mem_busy,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_wr,
           id_sel_ld, branch_taken, mem_busy,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage JOF32 pipeline. Tracks EX and MEM
// destinations in a shadow pipeline and drives stalls, flushes and forwarding selects.
//
// state   | meaning
// RUN     | normal issue
// LDSTALL | cycle after a load-use bubble; load now sits in MEM
// FLUSH   | remaining branch-penalty flush cycles
// MWAIT   | frozen on mem_busy; held_q remembers the state to resume
module pipeline_hazard_ctrl #(
  parameter int REG_AW         = 4,
  parameter int BRANCH_PENALTY = 1,
  parameter int ZERO_REG_HW    = 1,
  parameter int CNT_W          = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, MWAIT} state_e;

  localparam logic [2:0] PEN_M1 = 3'(BRANCH_PENALTY - 1);

  state_e            state_q, state_d, held_q, held_d, eff_s;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              ex_vld_q, ex_wr_q, ex_ld_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              mem_vld_q, mem_wr_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

  logic pc_en_s, if_id_en_s, if_id_flush_s, id_ex_en_s, bubble_s, ex_mem_en_s;
  logic stall_inc_s, flush_inc_s;
  logic ex_a_s, ex_b_s, mem_a_s, mem_b_s, load_use_s;

  function automatic logic match(input logic vld, input logic wr,
                                 input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] src, input logic used);
    return used && vld && wr && (rd == src) && !((ZERO_REG_HW != 0) && (rd == '0));
  endfunction

  // WB needs no shadow entry: the register file writes before it reads.
  always_comb begin
    ex_a_s     = match(ex_vld_q, ex_wr_q, ex_rd_q, hz.id_rs, hz.id_uses_rs);
    ex_b_s     = match(ex_vld_q, ex_wr_q, ex_rd_q, hz.id_rt, hz.id_uses_rt);
    mem_a_s    = match(mem_vld_q, mem_wr_q, mem_rd_q, hz.id_rs, hz.id_uses_rs);
    mem_b_s    = match(mem_vld_q, mem_wr_q, mem_rd_q, hz.id_rt, hz.id_uses_rt);
    load_use_s = hz.id_valid && ex_ld_q && (ex_a_s || ex_b_s);
  end

  always_comb begin
    pc_en_s       = 1'b1;
    if_id_en_s    = 1'b1;
    if_id_flush_s = 1'b0;
    id_ex_en_s    = 1'b1;
    bubble_s      = 1'b0;
    ex_mem_en_s   = 1'b1;
    stall_inc_s   = 1'b0;
    flush_inc_s   = 1'b0;
    state_d       = RUN;
    held_d        = held_q;
    fcnt_d        = fcnt_q;
    eff_s         = (state_q == MWAIT) ? held_q : state_q;
    if (rst) begin
      pc_en_s       = 1'b0;
      if_id_en_s    = 1'b0;
      id_ex_en_s    = 1'b0;
      ex_mem_en_s   = 1'b0;
      if_id_flush_s = 1'b1;
      bubble_s      = 1'b1;
    end else if (hz.mem_busy) begin
      pc_en_s     = 1'b0;
      if_id_en_s  = 1'b0;
      id_ex_en_s  = 1'b0;
      ex_mem_en_s = 1'b0;
      stall_inc_s = 1'b1;
      state_d     = MWAIT;
      held_d      = (eff_s == FLUSH) ? FLUSH : RUN;
    end else if (hz.branch_taken) begin
      if_id_flush_s = 1'b1;
      bubble_s      = 1'b1;
      flush_inc_s   = 1'b1;
      fcnt_d        = PEN_M1;
      state_d       = (PEN_M1 != 3'd0) ? FLUSH : RUN;
    end else if (eff_s == FLUSH) begin
      if_id_flush_s = 1'b1;
      bubble_s      = 1'b1;
      flush_inc_s   = 1'b1;
      fcnt_d        = fcnt_q - 3'd1;
      state_d       = (fcnt_q == 3'd1) ? RUN : FLUSH;
    end else if ((eff_s == RUN) && load_use_s) begin
      pc_en_s     = 1'b0;
      if_id_en_s  = 1'b0;
      bubble_s    = 1'b1;
      stall_inc_s = 1'b1;
      state_d     = LDSTALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      held_q      <= RUN;
      fcnt_q      <= 3'd0;
      ex_vld_q    <= 1'b0;
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_rd_q     <= '0;
      mem_vld_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      fcnt_q  <= fcnt_d;
      if (ex_mem_en_s) begin
        ex_vld_q  <= hz.id_valid && !bubble_s;
        ex_wr_q   <= hz.id_reg_wr;
        ex_ld_q   <= hz.id_sel_ld && hz.id_valid && !bubble_s;
        ex_rd_q   <= hz.id_rd;
        mem_vld_q <= ex_vld_q;
        mem_wr_q  <= ex_wr_q;
        mem_rd_q  <= ex_rd_q;
      end
      if (stall_inc_s && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc_s && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.pc_en        = pc_en_s;
  assign hz.if_id_en     = if_id_en_s;
  assign hz.if_id_flush  = if_id_flush_s;
  assign hz.id_ex_en     = id_ex_en_s;
  assign hz.id_ex_bubble = bubble_s;
  assign hz.ex_mem_en    = ex_mem_en_s;
  assign hz.fwd_a_sel    = rst ? 2'b00 : (ex_a_s && !ex_ld_q) ? 2'b01 : mem_a_s ? 2'b10 : 2'b00;
  assign hz.fwd_b_sel    = rst ? 2'b00 : (ex_b_s && !ex_ld_q) ? 2'b01 : mem_b_s ? 2'b10 : 2'b00;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (BRANCH_PENALTY = 3, ZERO_REG_HW = 1):
// forwarding, load-use stall, branch flush, mem_busy freeze, r0 handling and reset.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  pipeline_hazard_ctrl_if #(.REG_AW(4), .CNT_W(16)) bus ();

  pipeline_hazard_ctrl #(
    .REG_AW(4), .BRANCH_PENALTY(3), .ZERO_REG_HW(1), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic urs, input logic urt, input logic [3:0] rd,
                       input logic wr, input logic ld);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_uses_rs = urs;
    bus.id_uses_rt = urt;
    bus.id_rd      = rd;
    bus.id_reg_wr  = wr;
    bus.id_sel_ld  = ld;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.branch_taken = 1'b0;
    bus.mem_busy     = 1'b0;
    drive(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    chk("rst_pc_en",     32'(bus.pc_en), 0);
    chk("rst_if_id_en",  32'(bus.if_id_en), 0);
    chk("rst_id_ex_en",  32'(bus.id_ex_en), 0);
    chk("rst_ex_mem_en", 32'(bus.ex_mem_en), 0);
    chk("rst_flush",     32'(bus.if_id_flush), 1);
    chk("rst_bubble",    32'(bus.id_ex_bubble), 1);
    chk("rst_fwd_a",     32'(bus.fwd_a_sel), 0);
    step();
    step();
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    chk("rst_flush_cnt", 32'(bus.flush_cnt), 0);
    rst = 1'b0;

    // 1: ALU r3 -> consumer back-to-back, then with a NOP gap, then EX-over-MEM priority
    drive(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
    chk("run_pc_en",  32'(bus.pc_en), 1);
    chk("run_bubble", 32'(bus.id_ex_bubble), 0);
    chk("run_flush",  32'(bus.if_id_flush), 0);
    step();
    drive(1'b1, 4'd3, 4'd4, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
    chk("fwd_ex_a",   32'(bus.fwd_a_sel), 1);
    chk("fwd_ex_b0",  32'(bus.fwd_b_sel), 0);
    chk("fwd_ex_pc",  32'(bus.pc_en), 1);
    step();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
    step();
    nop();
    step();
    drive(1'b1, 4'd7, 4'd7, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    chk("fwd_mem_a",  32'(bus.fwd_a_sel), 2);
    chk("fwd_unused_b", 32'(bus.fwd_b_sel), 0);
    step();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd8, 4'd8, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    chk("fwd_prio_a", 32'(bus.fwd_a_sel), 1);
    chk("fwd_prio_b", 32'(bus.fwd_b_sel), 1);
    step();
    chk("no_stall_cnt", 32'(bus.stall_cnt), 0);

    // 2: load r5 then consumer reading r5 as rt
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1);
    step();
    drive(1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
    chk("lu_pc_en",     32'(bus.pc_en), 0);
    chk("lu_if_id_en",  32'(bus.if_id_en), 0);
    chk("lu_bubble",    32'(bus.id_ex_bubble), 1);
    chk("lu_ex_mem_en", 32'(bus.ex_mem_en), 1);
    step();
    chk("lu2_pc_en",  32'(bus.pc_en), 1);
    chk("lu2_bubble", 32'(bus.id_ex_bubble), 0);
    chk("lu2_fwd_b",  32'(bus.fwd_b_sel), 2);
    chk("lu2_stall_cnt", 32'(bus.stall_cnt), 1);
    step();
    chk("lu3_stall_cnt", 32'(bus.stall_cnt), 1);

    // 3: taken branch, penalty 3
    nop();
    bus.branch_taken = 1'b1;
    #1;
    chk("br0_flush",  32'(bus.if_id_flush), 1);
    chk("br0_bubble", 32'(bus.id_ex_bubble), 1);
    chk("br0_pc_en",  32'(bus.pc_en), 1);
    step();
    bus.branch_taken = 1'b0;
    #1;
    chk("br1_flush",  32'(bus.if_id_flush), 1);
    chk("br1_pc_en",  32'(bus.pc_en), 1);
    chk("br1_flush_cnt", 32'(bus.flush_cnt), 1);
    step();
    chk("br2_flush",  32'(bus.if_id_flush), 1);
    step();
    chk("br3_flush",  32'(bus.if_id_flush), 0);
    chk("br3_bubble", 32'(bus.id_ex_bubble), 0);
    chk("br3_flush_cnt", 32'(bus.flush_cnt), 3);

    // 4: load-use and branch in the same cycle (after a reset to clear counters)
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst2_stall_cnt", 32'(bus.stall_cnt), 0);
    chk("rst2_flush_cnt", 32'(bus.flush_cnt), 0);
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1);
    step();
    drive(1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    bus.branch_taken = 1'b1;
    #1;
    chk("brlu_flush", 32'(bus.if_id_flush), 1);
    chk("brlu_pc_en", 32'(bus.pc_en), 1);
    chk("brlu_if_id_en", 32'(bus.if_id_en), 1);
    step();
    bus.branch_taken = 1'b0;
    nop();
    chk("brlu_stall_cnt", 32'(bus.stall_cnt), 0);
    chk("brlu_flush_cnt", 32'(bus.flush_cnt), 1);

    // 5: mem_busy for 4 cycles while FLUSH has one cycle left
    step();
    chk("mw_pre_flush_cnt", 32'(bus.flush_cnt), 2);
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw_pc_en",     32'(bus.pc_en), 0);
      chk("mw_if_id_en",  32'(bus.if_id_en), 0);
      chk("mw_id_ex_en",  32'(bus.id_ex_en), 0);
      chk("mw_ex_mem_en", 32'(bus.ex_mem_en), 0);
      step();
    end
    bus.mem_busy = 1'b0;
    #1;
    chk("mw_stall_cnt", 32'(bus.stall_cnt), 4);
    chk("mw_resume_flush", 32'(bus.if_id_flush), 1);
    chk("mw_resume_pc_en", 32'(bus.pc_en), 1);
    chk("mw_hold_flush_cnt", 32'(bus.flush_cnt), 2);
    step();
    chk("mw_end_flush", 32'(bus.if_id_flush), 0);
    chk("mw_end_flush_cnt", 32'(bus.flush_cnt), 3);

    // 6: r0 never hazards; then reset pulsed in LDSTALL
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step();
    drive(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
    chk("r0_pc_en", 32'(bus.pc_en), 1);
    chk("r0_fwd_a", 32'(bus.fwd_a_sel), 0);
    chk("r0_fwd_b", 32'(bus.fwd_b_sel), 0);
    step();
    chk("r0_stall_cnt", 32'(bus.stall_cnt), 4);
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b1);
    step();
    drive(1'b1, 4'd6, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    chk("rs_lu_pc_en", 32'(bus.pc_en), 0);
    step();
    chk("rs_lu_stall_cnt", 32'(bus.stall_cnt), 5);
    rst = 1'b1;
    #1;
    chk("rs_mid_pc_en", 32'(bus.pc_en), 0);
    chk("rs_mid_flush", 32'(bus.if_id_flush), 1);
    step();
    rst = 1'b0;
    #1;
    chk("rs_stall_cnt", 32'(bus.stall_cnt), 0);
    chk("rs_flush_cnt", 32'(bus.flush_cnt), 0);
    chk("rs_fwd_a",     32'(bus.fwd_a_sel), 0);
    chk("rs_pc_en",     32'(bus.pc_en), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
